// File: rtl/lr_shift_stream.sv
// Command FIFO and result register that wrap an external combinational left/right shifter.
// The FIFO head is presented on sh_*, and sh_result is captured onto a valid/ready result stream.
module lr_shift_stream #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [width-1:0]         cmd_bits,
   input  logic [$clog2(width)-1:0] cmd_shift,
   input  logic                     cmd_dir,
   output logic [width-1:0]         sh_bits,
   output logic [$clog2(width)-1:0] sh_shift,
   output logic                     sh_dir,
   input  logic [width-1:0]         sh_result,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [width-1:0]         res_bits,
   output logic [$clog2(depth):0]   count
);

   localparam int unsigned SW = $clog2(width);
   localparam int unsigned PW = $clog2(depth);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(depth);

   logic [width-1:0] r_mem_bits  [depth];
   logic [SW-1:0]    r_mem_shift [depth];
   logic             r_mem_dir   [depth];

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_res_valid;
   logic [width-1:0] r_res_bits;

   logic w_nonempty;
   logic w_not_full;
   logic w_accept;
   logic w_xfer;

   // cmd_ready depends only on occupancy, so res_ready never reaches it combinationally.
   assign w_nonempty = (r_count != '0);
   assign w_not_full = (r_count < FULL);
   assign w_accept   = cmd_valid && w_not_full;
   assign w_xfer     = w_nonempty && (!r_res_valid || res_ready);

   assign cmd_ready = w_not_full;
   assign res_valid = r_res_valid;
   assign res_bits  = r_res_bits;
   assign count     = r_count;

   always_comb begin
      sh_bits  = '0;
      sh_shift = '0;
      sh_dir   = 1'b0;
      if (w_nonempty) begin
         sh_bits  = r_mem_bits[r_rd_ptr];
         sh_shift = r_mem_shift[r_rd_ptr];
         sh_dir   = r_mem_dir[r_rd_ptr];
      end
   end

   // Storage is deliberately left unreset; only entries below the occupancy count are ever read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_bits[r_wr_ptr]  <= cmd_bits;
         r_mem_shift[r_wr_ptr] <= cmd_shift;
         r_mem_dir[r_wr_ptr]   <= cmd_dir;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_res_valid <= 1'b0;
         r_res_bits  <= '0;
      end else begin
         if (w_accept)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_xfer)
            r_rd_ptr <= r_rd_ptr + PW'(1);

         case ({w_accept, w_xfer})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         if (w_xfer) begin
            r_res_bits  <= sh_result;
            r_res_valid <= 1'b1;
         end else if (res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lr_shift_stream.sv
// Self-checking bench for lr_shift_stream: directed vectors, back-pressure and wrap sequences,
// asynchronous reset, and random traffic scored against an arithmetic shift model.
module tb_lr_shift_stream;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_bits;
   logic [2:0] cmd_shift;
   logic       cmd_dir;
   logic [7:0] sh_bits;
   logic [2:0] sh_shift;
   logic       sh_dir;
   logic [7:0] sh_result;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_bits;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   int n_res    = 0;
   int cyc      = 0;
   logic [7:0] sb[$];
   int         take_cycs[$];

   lr_shift_stream #(.width(8), .depth(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_bits(cmd_bits), .cmd_shift(cmd_shift), .cmd_dir(cmd_dir),
      .sh_bits(sh_bits), .sh_shift(sh_shift), .sh_dir(sh_dir),
      .sh_result(sh_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_bits(res_bits),
      .count(count)
   );

   // External left/right shifter that the stage drives.
   always_comb sh_result = sh_dir ? (sh_bits >> sh_shift) : (sh_bits << sh_shift);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] ref_shift(input logic [7:0] b, input logic [2:0] s, input logic d);
      int unsigned v, p;
      v = b;
      p = 1;
      for (int unsigned k = 0; k < s; k++) p = p * 2;
      if (d) return 8'(v / p);
      return 8'((v * p) % 256);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock with scoreboard tracking: consumed results are compared, stalled results must hold.
   task automatic cycle();
      logic       acc, take, stall;
      logic [7:0] held;
      #1;
      acc   = cmd_valid && cmd_ready;
      take  = res_valid && res_ready;
      stall = res_valid && !res_ready;
      held  = res_bits;
      if (take) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_result: got 0x%0h, expected no result", res_bits);
         end else begin
            check("result_order", res_bits, sb.pop_front());
            n_res++;
            take_cycs.push_back(cyc);
         end
      end
      if (acc) begin
         sb.push_back(ref_shift(cmd_bits, cmd_shift, cmd_dir));
         n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (stall) begin
         check("stall_valid", res_valid, 1);
         check("stall_bits", res_bits, held);
      end
   endtask

   typedef struct {
      logic [7:0] bits;
      logic [2:0] shift;
      logic       dir;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] exp5[5];

   initial begin
      int res0, acc0, guard;

      vecs[0] = '{8'h81, 3'd1, 1'b0, 8'h02};
      vecs[1] = '{8'h81, 3'd3, 1'b1, 8'h10};
      vecs[2] = '{8'h81, 3'd0, 1'b0, 8'h81};
      vecs[3] = '{8'h81, 3'd0, 1'b1, 8'h81};
      vecs[4] = '{8'hFF, 3'd7, 1'b0, 8'h80};
      vecs[5] = '{8'hFF, 3'd7, 1'b1, 8'h01};
      vecs[6] = '{8'h5A, 3'd4, 1'b0, 8'hA0};
      vecs[7] = '{8'h5A, 3'd4, 1'b1, 8'h05};

      rst = 1'b0; cmd_valid = 1'b0; cmd_bits = '0; cmd_shift = '0; cmd_dir = 1'b0; res_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_count", count, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_bits", res_bits, 0);
      check("rst_sh_bits", sh_bits, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_cmd_ready", cmd_ready, 1);

      // Single commands through an empty FIFO with a free output register.
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmd_valid = 1'b1; cmd_bits = vecs[i].bits; cmd_shift = vecs[i].shift; cmd_dir = vecs[i].dir;
         tick();
         cmd_valid = 1'b0;
         check("vec_count_after_accept", count, 1);
         check("vec_no_bypass", res_valid, 0);
         check("vec_sh_bits", sh_bits, vecs[i].bits);
         check("vec_sh_shift", sh_shift, vecs[i].shift);
         check("vec_sh_dir", sh_dir, vecs[i].dir);
         tick();
         check("vec_res_valid", res_valid, 1);
         check("vec_res_bits", res_bits, vecs[i].exp);
         check("vec_count_drained", count, 0);
         check("vec_sh_zero", sh_bits, 0);
         tick();
         check("vec_valid_clears", res_valid, 0);
         check("vec_bits_hold", res_bits, vecs[i].exp);
      end

      // Back-pressure: fill output register plus FIFO, reject a sixth command, then drain in order.
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_bits  = 8'(8'h11 * (i + 1));
         cmd_shift = 3'(i);
         cmd_dir   = 1'(i % 2);
         exp5[i]   = ref_shift(cmd_bits, cmd_shift, cmd_dir);
         tick();
      end
      check("full_count", count, 4);
      check("full_cmd_ready", cmd_ready, 0);
      check("full_res_valid", res_valid, 1);
      cmd_bits = 8'hEE; cmd_shift = 3'd0; cmd_dir = 1'b0;
      tick();
      tick();
      check("full_no_overwrite_count", count, 4);
      check("full_stall_bits", res_bits, exp5[0]);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("drain_valid", res_valid, 1);
         check("drain_bits", res_bits, exp5[i]);
         check("drain_count", count, 32'(4 - i));
         tick();
      end
      check("drain_done_valid", res_valid, 0);
      check("drain_done_count", count, 0);

      // Sustained streaming through 16 commands; pointers wrap four times.
      sb.delete();
      take_cycs.delete();
      res0 = n_res;
      res_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cmd_valid = 1'b1;
         cmd_bits  = 8'($urandom);
         cmd_shift = 3'($urandom_range(0, 7));
         cmd_dir   = 1'($urandom_range(0, 1));
         cycle();
         if (i >= 1) check("stream_count_const", count, 1);
      end
      cmd_valid = 1'b0;
      repeat (3) cycle();
      check("stream_results", n_res - res0, 16);
      if (take_cycs.size() == 16)
         check("stream_one_per_cycle", take_cycs[15] - take_cycs[0], 15);
      check("stream_sb_empty", sb.size(), 0);

      // Random traffic with random back-pressure.
      sb.delete();
      res0 = n_res;
      acc0 = n_acc;
      guard = 0;
      while ((n_acc - acc0) < 200 && guard < 5000) begin
         cmd_valid = ((n_acc - acc0) < 200) && ($urandom_range(0, 3) != 0);
         cmd_bits  = 8'($urandom);
         cmd_shift = 3'($urandom_range(0, 7));
         cmd_dir   = 1'($urandom_range(0, 1));
         res_ready = 1'($urandom_range(0, 1));
         cycle();
         guard++;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      guard = 0;
      while ((sb.size() != 0 || res_valid) && guard < 50) begin
         cycle();
         guard++;
      end
      check("rand_accepted", n_acc - acc0, 200);
      check("rand_results", n_res - res0, 200);
      check("rand_sb_empty", sb.size(), 0);

      // Asynchronous reset with three queued commands and a pending result.
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_bits = 8'(8'h30 + i); cmd_shift = 3'd1; cmd_dir = 1'b0;
         tick();
      end
      cmd_valid = 1'b0;
      check("prerst_count", count, 3);
      check("prerst_res_valid", res_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_count", count, 0);
      check("async_rst_res_valid", res_valid, 0);
      check("async_rst_res_bits", res_bits, 0);
      check("async_rst_sh_bits", sh_bits, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      res_ready = 1'b1;
      repeat (4) tick();
      check("postrst_no_stale_valid", res_valid, 0);
      check("postrst_count", count, 0);
      sb.delete();
      res0 = n_res;
      cmd_valid = 1'b1; cmd_bits = 8'h81; cmd_shift = 3'd1; cmd_dir = 1'b0;
      cycle();
      cmd_valid = 1'b0;
      repeat (3) cycle();
      check("postrst_one_result", n_res - res0, 1);
      check("postrst_res_bits", res_bits, 8'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lr_shift_stream.md
LR_SHIFT_STREAM -- requirements
Module: lr_shift_stream

Streaming front/back stage for the left-right bits shifter: buffers shift commands, drives the shifter's combinational inputs, and registers its result onto a valid/ready output stream.

Interface
REQ-001 Parameter: width, 8, bit width of command data and result; SHALL be >= 2.
REQ-002 Parameter: depth, 4, command FIFO entries; SHALL be a power of two, >= 2.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: cmd_valid  in  1  command offered.
REQ-006 Port: cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-007 Port: cmd_bits  in  width  data to shift.
REQ-008 Port: cmd_shift  in  clog2(width)  shift amount.
REQ-009 Port: cmd_dir  in  1  ShiftDir: 0 = Left, 1 = Right.
REQ-010 Port: sh_bits  out  width  to shifter iBits.
REQ-011 Port: sh_shift  out  clog2(width)  to shifter shift.
REQ-012 Port: sh_dir  out  1  to shifter dir.
REQ-013 Port: sh_result  in  width  from shifter oBits; combinational function of sh_* ports.
REQ-014 Port: res_valid  out  1  result available.
REQ-015 Port: res_ready  in  1  downstream accepts result.
REQ-016 Port: res_bits  out  width  registered result.
REQ-017 Port: count  out  clog2(depth)+1  commands currently held in FIFO (excludes output register).

Function
REQ-018 FIFO SHALL be circular buffer with wr_ptr, rd_ptr (clog2(depth) bits, wrap depth-1 -> 0) and occupancy counter.
REQ-019 cmd_ready SHALL be high iff count < depth; registered-state only, no combinational path from res_ready.
REQ-020 sh_bits/sh_shift/sh_dir SHALL present FIFO head entry (rd_ptr) whenever count > 0; when count = 0 they SHALL be all-zero.
REQ-021 Transfer condition xfer = (count > 0) and (res_valid = 0 or res_ready = 1).
REQ-022 On xfer, res_bits SHALL load sh_result, res_valid SHALL go 1, rd_ptr SHALL advance; latency command accept -> res_valid = 1 cycle minimum (entry accepted at edge N visible at res at edge N+1 if FIFO was empty and output free).
REQ-023 When res_valid = 1, res_ready = 1 and not xfer, res_valid SHALL clear at next edge; res_bits SHALL hold value.
REQ-024 When res_valid = 1 and res_ready = 0, res_bits and res_valid SHALL hold stable.
REQ-025 Simultaneous accept and xfer SHALL leave count unchanged; accept only -> count+1; xfer only -> count-1.
REQ-026 Full (count = depth): cmd_ready = 0; command not written, no overwrite; simultaneous xfer frees slot visible next cycle.
REQ-027 Empty (count = 0): no xfer even if res_ready = 1; write-to-empty not bypassed to result in same cycle.
REQ-028 Ordering SHALL be strict FIFO; every accepted command yields exactly one result.
REQ-029 Shift amounts >= width cannot occur (width of cmd_shift); shift of 0 SHALL pass data unchanged.
REQ-030 Throughput: one result per cycle sustained when cmd_valid and res_ready held high.

Reset
REQ-031 While rst = 1: count = 0, wr_ptr = rd_ptr = 0, res_valid = 0, res_bits = 0, cmd_ready = 1 (after rst falls), sh_* = 0; FIFO data storage need not reset.
REQ-032 Reset asserted mid-operation SHALL discard all queued commands and pending result immediately, without waiting for clk.

Verification
REQ-033 width=8: cmd 0x81, shift 1, dir 0, res_ready 1 -> next cycle res_valid 1, res_bits 0x02.
REQ-034 cmd 0x81, shift 3, dir 1 -> res_bits 0x10; shift 0 either dir -> 0x81.
REQ-035 res_ready 0, push 5 commands back-to-back -> 1 in output register, 4 in FIFO, count 4, cmd_ready 0, 6th command not accepted; release res_ready -> 5 results in order.
REQ-036 Continuous cmd_valid and res_ready for 16 cycles, pointers wrap -> 16 results in order, one per cycle, count constant.
REQ-037 Assert rst asynchronously with count 3 and res_valid 1 -> res_valid and count 0 before next clk edge; no stale results after release.
REQ-038 res_ready toggling randomly for 200 commands -> scoreboard matches reference shift model, no loss/duplication, res_bits stable while stalled.
